// File: rtl/jtdd_pkg.sv
// +--------------------------------------------------------------------------+
// | jtdd_pkg: shared FSM encoding and line geometry for the char ROM fetcher |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package jtdd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam int LINE_BYTES = 4;
  localparam int SEL_W      = $clog2(LINE_BYTES);

  function automatic int tag_width(input int aw);
    return aw - SEL_W;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jtdd_romrq_line.sv
// +--------------------------------------------------------------------------+
// | jtdd_romrq_line: one cache line (valid/tag/data, tag compare, byte mux)  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module jtdd_romrq_line
  import jtdd_pkg::*;
#(
  parameter int TW = 13
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [TW-1:0]    wtag,
  input  logic [31:0]      wdata,
  input  logic [TW-1:0]    tag,
  input  logic [SEL_W-1:0] sel,
  output logic             hit,
  output logic [7:0]       rdata
);

  logic          valid_r;
  logic [TW-1:0] tag_r;
  logic [31:0]   data_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      tag_r   <= '0;
      data_r  <= '0;
    end else if (we) begin
      valid_r <= 1'b1;
      tag_r   <= wtag;
      data_r  <= wdata;
    end
  end

  assign hit = valid_r && (tag_r == tag);

  always_comb begin
    rdata = data_r[7:0];
    case (sel)
      2'd0:    rdata = data_r[7:0];
      2'd1:    rdata = data_r[15:8];
      2'd2:    rdata = data_r[23:16];
      default: rdata = data_r[31:24];
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/jtdd_char_romrq.sv
// +--------------------------------------------------------------------------+
// | jtdd_char_romrq: 2-line cached ROM responder for the character layer     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module jtdd_char_romrq
  import jtdd_pkg::*;
#(
  parameter int             AW     = 15,
  parameter int             SDW    = 22,
  parameter logic [SDW-1:0] OFFSET = '0
)(
  input  logic           clk,
  input  logic           rst,
  input  logic [AW-1:0]  addr,
  input  logic           addr_ok,
  output logic [7:0]     dout,
  output logic           data_ok,
  output logic [SDW-1:0] sdram_addr,
  output logic           sdram_req,
  input  logic           sdram_ack,
  input  logic           data_rdy,
  input  logic [31:0]    sdram_din
);

  localparam int TW = tag_width(AW);

  state_t            state, state_nxt;
  logic [TW-1:0]     tag;
  logic [SEL_W-1:0]  sel;
  logic [TW-1:0]     pend_tag;
  logic              lru;
  logic              victim;
  logic [7:0]        dout_r;
  logic [1:0]        line_hit;
  logic [1:0]        line_we;
  logic [7:0]        line_byte [2];
  logic              hit;
  logic              hit_idx;
  logic [7:0]        hit_byte;
  logic              start;
  logic              fill;
  logic              fill_idx;

  assign tag = addr[AW-1:SEL_W];
  assign sel = addr[SEL_W-1:0];

  for (genvar i = 0; i < 2; i++) begin : g_line
    jtdd_romrq_line #(.TW(TW)) u_line (
      .clk   (clk),
      .rst   (rst),
      .we    (line_we[i]),
      .wtag  (pend_tag),
      .wdata (sdram_din),
      .tag   (tag),
      .sel   (sel),
      .hit   (line_hit[i]),
      .rdata (line_byte[i])
    );
  end

  assign hit      = addr_ok && (|line_hit);
  assign hit_idx  = line_hit[1];
  assign hit_byte = hit_idx ? line_byte[1] : line_byte[0];
  assign data_ok  = hit;
  assign dout     = hit ? hit_byte : dout_r;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (addr_ok && !hit) state_nxt = ST_REQ;
      ST_REQ:  if (sdram_ack)       state_nxt = data_rdy ? ST_IDLE : ST_WAIT;
      ST_WAIT: if (data_rdy)        state_nxt = ST_IDLE;
      default:                      state_nxt = ST_IDLE;
    endcase
  end

  // A line hit in the fill cycle is never the one overwritten.
  always_comb begin
    start    = (state == ST_IDLE) && addr_ok && !hit;
    fill     = ((state == ST_REQ) && sdram_ack && data_rdy) ||
               ((state == ST_WAIT) && data_rdy);
    fill_idx = hit ? ~hit_idx : victim;
    line_we  = fill ? (fill_idx ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      pend_tag   <= '0;
      victim     <= 1'b0;
      lru        <= 1'b0;
      dout_r     <= '0;
    end else begin
      if (start) begin
        sdram_req  <= 1'b1;
        sdram_addr <= OFFSET + SDW'({tag, 1'b0});
        pend_tag   <= tag;
        victim     <= lru;
      end else if (hit && (state != ST_IDLE)) begin
        victim <= ~hit_idx;
      end
      if ((state == ST_REQ) && sdram_ack) sdram_req <= 1'b0;
      if (fill)     lru <= ~fill_idx;
      else if (hit) lru <= ~hit_idx;
      if (hit) dout_r <= hit_byte;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jtdd_char_romrq.sv
// +--------------------------------------------------------------------------+
// | tb_jtdd_char_romrq: directed + random bench with an MRU-list ROM model   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_jtdd_char_romrq;

  localparam logic [21:0] OFF1 = 22'h0;
  localparam logic [21:0] OFF2 = 22'h10000;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] addr;
  logic        addr_ok;
  logic        sdram_ack;
  logic        data_rdy;
  logic [31:0] sdram_din;
  logic [7:0]  dout,  dout2;
  logic        data_ok, data_ok2;
  logic [21:0] sdram_addr, sdram_addr2;
  logic        sdram_req, sdram_req2;

  always #5 clk = ~clk;

  jtdd_char_romrq #(.AW(15), .SDW(22), .OFFSET(OFF1)) u_dut (
    .clk(clk), .rst(rst), .addr(addr), .addr_ok(addr_ok),
    .dout(dout), .data_ok(data_ok), .sdram_addr(sdram_addr), .sdram_req(sdram_req),
    .sdram_ack(sdram_ack), .data_rdy(data_rdy), .sdram_din(sdram_din)
  );

  jtdd_char_romrq #(.AW(15), .SDW(22), .OFFSET(OFF2)) u_dut2 (
    .clk(clk), .rst(rst), .addr(addr), .addr_ok(addr_ok),
    .dout(dout2), .data_ok(data_ok2), .sdram_addr(sdram_addr2), .sdram_req(sdram_req2),
    .sdram_ack(sdram_ack), .data_rdy(data_rdy), .sdram_din(sdram_din)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Model: cached tags in MRU-first order, plus the outstanding fetch.
  logic [12:0] mq [$];
  logic [31:0] mdata [logic [12:0]];
  int          phase = 0;
  logic [12:0] mpend = '0;
  logic        mreq  = 1'b0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", name, obs, expv);
    end
  endtask

  function automatic int find_tag(input logic [12:0] t);
    foreach (mq[k]) if (mq[k] == t) return k;
    return -1;
  endfunction

  task automatic model_fill(input logic [31:0] din);
    int k;
    k = find_tag(mpend);
    if (k >= 0) mq.delete(k);
    mq.push_front(mpend);
    if (mq.size() > 2) void'(mq.pop_back());
    mdata[mpend] = din;
    phase = 0;
  endtask

  task automatic step(input logic r, input logic [14:0] a, input logic ok,
                      input logic ak, input logic rd, input logic [31:0] din);
    logic [12:0] t;
    int          k;
    logic        h;
    @(negedge clk);
    rst = r; addr = a; addr_ok = ok; sdram_ack = ak; data_rdy = rd; sdram_din = din;
    #1;
    t = a[14:2];
    k = find_tag(t);
    h = ok && (k >= 0);
    if (!r) begin
      chk("data_ok", data_ok, h);
      if (h) chk("dout", dout, mdata[t][8*a[1:0] +: 8]);
      chk("sdram_req", sdram_req, mreq);
      chk("sdram_req_off", sdram_req2, mreq);
      if (mreq) begin
        chk("sdram_addr", sdram_addr, OFF1 + {8'h0, mpend, 1'b0});
        chk("sdram_addr_off", sdram_addr2, OFF2 + {8'h0, mpend, 1'b0});
      end
    end
    if (r) begin
      mq.delete();
      phase = 0;
      mreq  = 1'b0;
    end else begin
      if (h) begin
        mq.delete(k);
        mq.push_front(t);
      end
      case (phase)
        0: if (ok && !h) begin mpend = t; phase = 1; mreq = 1'b1; end
        1: if (ak) begin
             mreq = 1'b0;
             if (rd) model_fill(din);
             else    phase = 2;
           end
        default: if (rd) model_fill(din);
      endcase
    end
  endtask

  task automatic fetch(input logic [14:0] a, input logic [31:0] din);
    step(1'b0, a, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, a, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, a, 1'b1, 1'b0, 1'b1, din);
  endtask

  localparam logic [14:0] A_ADDR = 15'h0400;
  localparam logic [14:0] B_ADDR = 15'h0800;
  localparam logic [14:0] C_ADDR = 15'h0C00;
  localparam logic [14:0] X_ADDR = 15'h1400;
  localparam logic [14:0] Y_ADDR = 15'h1800;
  localparam logic [14:0] Z_ADDR = 15'h1C00;

  initial begin
    logic [12:0] tags [6];
    logic [14:0] ra;
    logic        rok, rak, rrd, rr;

    rst = 1'b1; addr = '0; addr_ok = 1'b0; sdram_ack = 1'b0; data_rdy = 1'b0; sdram_din = '0;
    step(1'b1, 15'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 15'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    step(1'b0, 15'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("reset_dout", dout, 8'h00);
    chk("reset_data_ok", data_ok, 1'b0);

    // First fetch, then a second byte of the same line without a new request
    fetch(15'h0004, 32'hDDCCBBAA);
    step(1'b0, 15'h0004, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("first_byte", dout, 8'hAA);
    step(1'b0, 15'h0007, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("same_line_byte", dout, 8'hDD);
    step(1'b0, 15'h0007, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("no_new_req", sdram_req, 1'b0);

    // Top-of-range address through both offsets
    step(1'b0, 15'h7FFC, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 15'h7FFC, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("base_addr", sdram_addr, 22'h003FFE);
    chk("offset_addr", sdram_addr2, 22'h013FFE);
    step(1'b0, 15'h7FFC, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 15'h7FFC, 1'b1, 1'b0, 1'b1, 32'h44332211);

    // LRU eviction: A, B, hit A, C evicts B
    step(1'b1, 15'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    fetch(A_ADDR, 32'hA0A1A2A3);
    fetch(B_ADDR, 32'hB0B1B2B3);
    step(1'b0, A_ADDR, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("hit_a", data_ok, 1'b1);
    fetch(C_ADDR, 32'hC0C1C2C3);
    step(1'b0, A_ADDR, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("a_kept", data_ok, 1'b1);
    step(1'b0, B_ADDR, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("b_evicted", data_ok, 1'b0);
    step(1'b0, B_ADDR, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, B_ADDR, 1'b0, 1'b0, 1'b1, 32'hB4B5B6B7);

    // Hit on a cached line while a miss is pending, including the fill cycle
    step(1'b0, X_ADDR, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, X_ADDR, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, A_ADDR + 15'd2, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("hit_during_wait", data_ok, 1'b1);
    step(1'b0, A_ADDR + 15'd1, 1'b1, 1'b0, 1'b1, 32'h58595A5B);
    step(1'b0, A_ADDR, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("a_survives_fill", data_ok, 1'b1);
    step(1'b0, X_ADDR + 15'd3, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("x_filled", dout, 8'h58);

    // Reset during WAIT, then a stale data_rdy
    step(1'b0, Y_ADDR, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, Y_ADDR, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, Y_ADDR, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, Y_ADDR, 1'b0, 1'b0, 1'b1, 32'h12345678);
    chk("rst_req_low", sdram_req, 1'b0);
    step(1'b0, A_ADDR, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst_invalidates", data_ok, 1'b0);
    step(1'b0, A_ADDR, 1'b0, 1'b1, 1'b1, 32'hA0A1A2A3);

    // ack and data_rdy in the same cycle
    step(1'b0, Z_ADDR, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, Z_ADDR, 1'b0, 1'b1, 1'b1, 32'h9ABCDEF0);
    step(1'b0, Z_ADDR, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("ack_rdy_idle", sdram_req, 1'b0);
    step(1'b0, Z_ADDR + 15'd1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("ack_rdy_fill", dout, 8'hDE);

    // Randomized traffic over a small tag set
    for (int i = 0; i < 6; i++) tags[i] = 13'($urandom());
    for (int n = 0; n < 800; n++) begin
      ra  = {tags[$urandom_range(0, 5)], 2'($urandom_range(0, 3))};
      rok = ($urandom_range(0, 3) != 0);
      rak = 1'b0;
      rrd = 1'b0;
      if (phase == 1) begin
        rak = ($urandom_range(0, 1) == 1);
        rrd = rak ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      end else if (phase == 2) begin
        rrd = ($urandom_range(0, 2) == 0);
      end else begin
        rak = ($urandom_range(0, 19) == 0);
        rrd = ($urandom_range(0, 19) == 0);
      end
      rr = ($urandom_range(0, 99) == 0);
      step(rr, ra, rok, rak, rrd, $urandom());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/jtdd_char_romrq.md
Name: jtdd_char_romrq

Overview:
- ROM-side responder for the character layer's graphics fetches.
- Accepts a 15-bit byte address with a valid strobe from the character layer and returns the addressed byte plus a data-ok flag.
- Hits are served combinationally from a 2-line, 32-bit-per-line cache; misses trigger one 32-bit SDRAM read through the frame's req/ack/data_rdy handshake.
- Sits between the character layer and the SDRAM arbiter in the game top level.

Parameters:
- AW, 15, byte address width from the layer
- OFFSET, 22'h0, SDRAM 16-bit-word base address of the char ROM region
- SDW, 22, SDRAM address width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- addr  in  AW  byte address requested by the character layer
- addr_ok  in  1  addr valid; when low, no fetch is started
- dout  out  8  byte at addr
- data_ok  out  1  dout valid for the current addr
- sdram_addr  out  SDW  16-bit word address of the line to read
- sdram_req  out  1  read request, held until acknowledged
- sdram_ack  in  1  arbiter accepted the request (1-cycle pulse)
- data_rdy  in  1  sdram_din valid (1-cycle pulse)
- sdram_din  in  32  line data; byte n = sdram_din[8n+7:8n]

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst); both are fixed.
- Line tag: addr[AW-1:2] (13 bits). Byte select: addr[1:0].
- Cache: 2 entries, each holding valid, tag and data[31:0], plus one LRU bit pointing at the victim.
- Hit: addr_ok and any valid entry whose tag equals addr[14:2].
  - data_ok=1 combinationally in the same cycle.
  - dout = selected byte of the hit entry.
  - Registered update: LRU set to point at the other entry.
- Miss or addr_ok=0: data_ok=0. dout holds its last value (registered mux output). It is don't-care to the bench when data_ok=0.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: on addr_ok and miss, latch tag into pend_tag, drive sdram_addr = OFFSET + {pend_tag,1'b0} (mod 2^SDW), set sdram_req=1, go to REQ.
  - REQ: hold sdram_req and sdram_addr stable. On sdram_ack, clear sdram_req and go to WAIT.
  - WAIT: on data_rdy, write sdram_din and pend_tag into the LRU victim, set valid, point LRU at the other entry, go to IDLE.
  - data_ok for the filled line may first assert the cycle after data_rdy (the fill is registered).
- Address change mid-fetch: the pending fetch always completes and fills with pend_tag. The new address is evaluated in IDLE afterwards. There is no cancellation.
- Hit on the other entry while REQ or WAIT: served normally; LRU is updated by the hit.
  - At the fill cycle, the fill's LRU update takes priority.
  - The fill never overwrites the entry hit in that same cycle.
  - To guarantee this, the victim is latched on entry to REQ and the other entry is protected.
- sdram_ack and data_rdy in the same cycle while in REQ: treated as ack then data. Fill happens and FSM goes to IDLE directly.
- data_rdy or sdram_ack in IDLE: ignored. This covers stale responses after reset.
- Reset values: all valid=0, LRU=0, FSM=IDLE, sdram_req=0, sdram_addr=0, dout=0. data_ok=0 follows from valid=0.
- Reset mid-fetch: sdram_req drops the next cycle, no fill occurs, and a later data_rdy is ignored.
- Back-to-back misses: at most one outstanding SDRAM request; a new request is issued the cycle after returning to IDLE.

Decomposition:
- Shared package jtdd_pkg holds:
  - FSM state encoding (IDLE=2'd0, REQ=2'd1, WAIT=2'd2)
  - line size constant (4 bytes)
  - tag width derivation
- One natural sub-module, jtdd_romrq_line: a single cache entry (valid/tag/data registers, tag compare, byte mux). Instantiated twice.

Test Plan:
- Reset, then addr=15'h0004, addr_ok=1 -> one sdram_req with sdram_addr=22'h2. After ack and data_rdy with din=32'hDDCCBBAA, data_ok=1 and dout=8'hAA. Then addr=15'h0007 -> dout=8'hDD with no new request.
- OFFSET=22'h10000, addr=15'h7FFC -> sdram_addr=22'h13FFE.
- Fill tags A, then B. Hit A. Access new tag C -> B is evicted. A still hits; B misses and issues a request.
- Miss on tag X pending in WAIT. Switch addr to already-cached tag A -> immediate data_ok=1. After data_rdy, X is cached and A is not evicted.
- Assert rst while in WAIT, then pulse data_rdy -> no fill. Prior lines invalid. data_ok=0. sdram_req=0.
- sdram_ack and data_rdy in the same cycle -> fill completes and FSM returns to IDLE. addr_ok=0 -> no request issued.
